// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types and constants for the bit-serial transmitter.
//   ser_state_t       - transmitter FSM states
//   WORD_W            - parallel word width
//   DEF_*_CYCLES      - default strobe/gap/frame timing, shared with the deserializer bench
//   max3()            - helper used to size the cycle counter
package serializer_pkg;

  localparam int WORD_W            = 8;
  localparam int DEF_STROBE_CYCLES = 10;
  localparam int DEF_GAP_CYCLES    = 10;
  localparam int DEF_FRAME_CYCLES  = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    FRAME  = 2'd3
  } ser_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serializer_cycle_timer.sv
// cycle_timer: loadable down-counter with a terminal flag.
//   clk, rst_n  - clock, async active-low reset
//   i_load      - load i_val this edge (takes priority over counting)
//   i_val       - reload value (phase length minus one)
//   o_done      - counter is at zero; holds there until reloaded
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Saturates at zero so it never wraps while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cnt <= '0;
    else if (i_load)        r_cnt <= i_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/serializer.sv
// serializer: parallel-to-serial transmitter, LSB first.
//   clock_1MHz    - block clock, rising edge
//   rst           - async active-low reset
//   data_in[7:0]  - word, sampled only on the accept edge
//   load_in       - transmit request, honoured only while idle
//   status_out    - 1 = idle and ready
//   data_out      - serial bit, stable across its strobe and gap
//   write_out     - per-bit strobe (STROBE_CYCLES high, GAP_CYCLES low)
//   enqueue_out   - end-of-frame strobe (FRAME_CYCLES high)
//   busy_bit_out  - index of the bit currently on data_out
module serializer
  import serializer_pkg::*;
#(
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int FRAME_CYCLES  = DEF_FRAME_CYCLES
) (
  input  logic              clock_1MHz,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              load_in,
  output logic              status_out,
  output logic              data_out,
  output logic              write_out,
  output logic              enqueue_out,
  output logic [2:0]        busy_bit_out
);

  localparam int CNT_W = $clog2(max3(STROBE_CYCLES, GAP_CYCLES, FRAME_CYCLES) + 1);
  // Timer is loaded with length-1 on state entry; done marks the last cycle.
  localparam logic [CNT_W-1:0] LD_HI = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_LO = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_FR = CNT_W'(FRAME_CYCLES - 1);

  ser_state_t        r_state, w_nxt;
  logic [WORD_W-1:0] r_shreg;
  logic [2:0]        r_idx, w_idx_nxt;
  logic              w_accept, w_tmr_load, w_tmr_done, w_data_nxt;
  logic [CNT_W-1:0]  w_tmr_val;
  logic              r_status, r_data, r_write, r_enq;

  cycle_timer #(.W(CNT_W)) u_timer (
    .clk    (clock_1MHz),
    .rst_n  (rst),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_done (w_tmr_done)
  );

  always_comb begin
    w_nxt      = r_state;
    w_idx_nxt  = r_idx;
    w_accept   = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      IDLE: if (load_in) begin
        w_accept   = 1'b1;
        w_nxt      = BIT_HI;
        w_idx_nxt  = 3'd0;
        w_tmr_load = 1'b1;
        w_tmr_val  = LD_HI;
      end
      BIT_HI: if (w_tmr_done) begin
        w_nxt      = BIT_LO;
        w_tmr_load = 1'b1;
        w_tmr_val  = LD_LO;
      end
      BIT_LO: if (w_tmr_done) begin
        w_tmr_load = 1'b1;
        if (r_idx == 3'd7) begin
          w_nxt     = FRAME;
          w_tmr_val = LD_FR;
        end else begin
          w_nxt     = BIT_HI;
          w_idx_nxt = r_idx + 3'd1;
          w_tmr_val = LD_HI;
        end
      end
      FRAME: if (w_tmr_done) begin
        w_nxt     = IDLE;
        w_idx_nxt = 3'd0;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  // On the accept edge the shift register is not yet loaded, so bit 0
  // comes straight from data_in.
  always_comb begin
    w_data_nxt = 1'b0;
    if (w_nxt == BIT_HI || w_nxt == BIT_LO)
      w_data_nxt = w_accept ? data_in[0] : r_shreg[w_idx_nxt];
  end

  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_idx    <= 3'd0;
      r_status <= 1'b1;
      r_data   <= 1'b0;
      r_write  <= 1'b0;
      r_enq    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_idx    <= w_idx_nxt;
      if (w_accept) r_shreg <= data_in;
      r_status <= (w_nxt == IDLE);
      r_write  <= (w_nxt == BIT_HI);
      r_enq    <= (w_nxt == FRAME);
      r_data   <= w_data_nxt;
    end
  end

  assign status_out   = r_status;
  assign data_out     = r_data;
  assign write_out    = r_write;
  assign enqueue_out  = r_enq;
  assign busy_bit_out = r_idx;

endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed bench for serializer. A default-timing instance
// feeds a small receiver model; a 1/1/1-timing instance covers the minimum
// parameter case.
module tb_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       d_load = 1'b0, f_load = 1'b0;
  logic       d_status, d_data, d_write, d_enq;
  logic       f_status, f_data, f_write, f_enq;
  logic [2:0] d_busy, f_busy;

  int tests = 0, fails = 0;
  logic sel_fast = 1'b0;

  always #5 clk = ~clk;

  serializer u_dut (
    .clock_1MHz(clk), .rst(rst_n), .data_in(data_in), .load_in(d_load),
    .status_out(d_status), .data_out(d_data), .write_out(d_write),
    .enqueue_out(d_enq), .busy_bit_out(d_busy)
  );

  serializer #(.STROBE_CYCLES(1), .GAP_CYCLES(1), .FRAME_CYCLES(1)) u_fast (
    .clock_1MHz(clk), .rst(rst_n), .data_in(data_in), .load_in(f_load),
    .status_out(f_status), .data_out(f_data), .write_out(f_write),
    .enqueue_out(f_enq), .busy_bit_out(f_busy)
  );

  logic       m_status, m_data, m_write, m_enq;
  logic [2:0] m_busy;
  assign m_status = sel_fast ? f_status : d_status;
  assign m_data   = sel_fast ? f_data   : d_data;
  assign m_write  = sel_fast ? f_write  : d_write;
  assign m_enq    = sel_fast ? f_enq    : d_enq;
  assign m_busy   = sel_fast ? f_busy   : d_busy;

  // Receiver model: sample data on write rising, push word on enqueue rising.
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh;
  int         rx_n;
  logic       rx_pw, rx_pe;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh <= 8'h00; rx_n <= 0; rx_pw <= 1'b0; rx_pe <= 1'b0;
    end else begin
      if (d_write && !rx_pw) begin
        rx_sh <= {d_data, rx_sh[7:1]};
        rx_n  <= rx_n + 1;
      end
      if (d_enq && !rx_pe) begin
        if (rx_n == 8) rx_q.push_back(rx_sh);
        rx_n <= 0;
      end
      rx_pw <= d_write;
      rx_pe <= d_enq;
    end
  end

  task automatic set_load(input logic v);
    if (sel_fast) f_load = v; else d_load = v;
  endtask

  // Called at a negedge while idle; returns at the first negedge after accept.
  task automatic start(input logic [7:0] w);
    data_in = w;
    set_load(1'b1);
    @(negedge clk);
  endtask

  // Checks every cycle of a frame from the first cycle after accept, then
  // the ready cycle 8*(S+G)+F cycles after the accept edge.
  task automatic check_frame(input logic [7:0] w, input logic drop, input string nm);
    int s, g, f, p, l, b, bad, badk;
    logic ew, ed, ee;
    logic [2:0] eb;
    string first;
    s = sel_fast ? 1 : 10; g = sel_fast ? 1 : 10; f = sel_fast ? 1 : 20;
    p = s + g; l = 8 * p + f; bad = 0; badk = -1; first = "";
    for (int k = 0; k < l; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0 && drop) set_load(1'b0);
      if (k < 8 * p) begin
        b = k / p; ew = (k % p) < s; ed = w[b]; ee = 1'b0; eb = 3'(b);
      end else begin
        b = 0; ew = 1'b0; ed = 1'b0; ee = 1'b1; eb = m_busy;
      end
      if (m_write !== ew || m_data !== ed || m_enq !== ee || m_status !== 1'b0 || m_busy !== eb) begin
        bad++;
        if (badk < 0) begin
          badk = k;
          first = $sformatf("w/d/e/s/bit=%b%b%b%b/%0d required %b%b%b0/%0d",
                            m_write, m_data, m_enq, m_status, m_busy, ew, ed, ee, eb);
        end
      end
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL %s wave: %0d bad cycles, first at cycle %0d got %s", nm, bad, badk, first);
    end
    @(negedge clk);
    tests++;
    if (m_status !== 1'b1 || m_write !== 1'b0 || m_enq !== 1'b0 || m_data !== 1'b0) begin
      fails++;
      $display("FAIL %s ready at %0d: s/w/e/d=%b%b%b%b required 1000", nm, l,
               m_status, m_write, m_enq, m_data);
    end
  endtask

  task automatic test_reset();
    d_load = 1'b1; f_load = 1'b1; data_in = 8'hFF;
    repeat (3) @(negedge clk);
    tests++;
    if ({d_status, d_data, d_write, d_enq, d_busy} !== 7'b1000_000) begin
      fails++;
      $display("FAIL reset dflt: s/d/w/e/bit=%b%b%b%b/%0d required 1000/0", d_status, d_data, d_write, d_enq, d_busy);
    end
    tests++;
    if ({f_status, f_data, f_write, f_enq, f_busy} !== 7'b1000_000) begin
      fails++;
      $display("FAIL reset fast: s/d/w/e/bit=%b%b%b%b/%0d required 1000/0", f_status, f_data, f_write, f_enq, f_busy);
    end
    d_load = 1'b0; f_load = 1'b0; rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (d_status !== 1'b1 || d_write !== 1'b0 || f_status !== 1'b1 || f_write !== 1'b0) begin
      fails++;
      $display("FAIL reset noframe: status d/f=%b%b write d/f=%b%b required 11 00", d_status, f_status, d_write, f_write);
    end
  endtask

  task automatic test_x80();
    rx_q.delete();
    start(8'h80);
    check_frame(8'h80, 1'b1, "x80");
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h80) begin
      fails++;
      $display("FAIL x80 rx: got %0d words first %h required 1 word 80", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_ignore();
    int wr;
    rx_q.delete();
    start(8'hA5);
    fork
      check_frame(8'hA5, 1'b1, "xA5");
      begin
        repeat (50) @(negedge clk);
        data_in = 8'hFF; d_load = 1'b1;
        @(negedge clk);
        d_load = 1'b0;
      end
    join
    wr = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (d_write !== 1'b0 || d_status !== 1'b1) wr++;
    end
    tests++;
    if (wr !== 0) begin
      fails++;
      $display("FAIL xA5 second load: %0d non-idle cycles after frame, required 0", wr);
    end
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      fails++;
      $display("FAIL xA5 rx: got %0d words first %h required 1 word a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    rx_q.delete();
    start(8'h01);
    data_in = 8'h02;
    check_frame(8'h01, 1'b0, "b2b1");
    @(negedge clk);
    check_frame(8'h02, 1'b1, "b2b2");
    tests++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h01 || rx_q[1] !== 8'h02) begin
      fails++;
      $display("FAIL b2b rx: got %0d words, required 01 02", rx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    rx_q.delete();
    start(8'hFF);
    d_load = 1'b0;
    repeat (63) @(negedge clk);
    tests++;
    if (d_write !== 1'b1 || d_data !== 1'b1 || d_busy !== 3'd3) begin
      fails++;
      $display("FAIL rstmid pre: w/d/bit=%b%b/%0d required 11/3", d_write, d_data, d_busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({d_status, d_data, d_write, d_enq, d_busy} !== 7'b1000_000) begin
      fails++;
      $display("FAIL rstmid async: s/d/w/e/bit=%b%b%b%b/%0d required 1000/0", d_status, d_data, d_write, d_enq, d_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start(8'h3C);
    check_frame(8'h3C, 1'b1, "x3C");
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      fails++;
      $display("FAIL x3C rx: got %0d words first %h required 1 word 3c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_fast();
    sel_fast = 1'b1;
    start(8'h55);
    check_frame(8'h55, 1'b1, "fast55");
    sel_fast = 1'b0;
  endtask

  initial begin
    test_reset();
    test_x80();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_fast();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
